alu_exec_unit: RTL and testbench

- Execution-side consumer of the ALU decoder outputs.
- Takes alu_control and flag_w from the decoder, executes the operation on two operands and updates the architectural NZCV flag register according to flag_w.
- Single-cycle ops (add/sub/logic/shift) complete in one cycle. MUL and UDIV run iteratively over WIDTH cycles behind a start/busy/done handshake.
- Sits between the register file read stage and writeback/conditional logic in the processor datapath.

---
 rtl/alu_exec_unit.sv | 194 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: executes decoded ALU ops and maintains the NZCV flag register.
// Single-cycle ops finish on the accepting edge. MUL (shift-add) and UDIV
// (restoring) iterate one bit per cycle for WIDTH cycles.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [1:0]       flag_w,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       nzcv,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_EOR  = 4'b0100;
    localparam logic [3:0] OP_LSL  = 4'b0101;
    localparam logic [3:0] OP_LSR  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_UDIV = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

    state_t               r_state;
    logic [SHW-1:0]       r_cnt;
    logic [1:0]           r_fw;
    logic [2*WIDTH-1:0]   r_p;      // {partial product high, remaining multiplier bits}
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]     r_dvs;

    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH:0]       w_lsl;
    logic [WIDTH:0]       w_lsr;
    logic [WIDTH-1:0]     w_res;
    logic [WIDTH-1:0]     w_hi;
    logic                 w_c;
    logic                 w_v;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_t;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_q_next;

    // Merge new flags into the held register under the write enables.
    function automatic logic [3:0] f_nzcv(input logic [3:0] old, input logic [1:0] fw,
                                          input logic [WIDTH-1:0] res, input logic c,
                                          input logic v);
        logic [3:0] f;
        f[3:2] = fw[1] ? {res[WIDTH-1], (res == '0)} : old[3:2];
        f[1:0] = fw[0] ? {c, v} : old[1:0];
        return f;
    endfunction

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};
    assign w_lsl = {1'b0, a} << b[SHW-1:0];
    assign w_lsr = {a, 1'b0} >> b[SHW-1:0];

    // Single-cycle datapath; the extra bit of each shift catches the last bit shifted out.
    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_control)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = ~w_sub[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_ORR: w_res = a | b;
            OP_EOR: w_res = a ^ b;
            OP_LSL: begin
                w_res = w_lsl[WIDTH-1:0];
                w_c   = w_lsl[WIDTH];
            end
            OP_LSR: begin
                w_res = w_lsr[WIDTH:1];
                w_c   = w_lsr[0];
            end
            OP_UDIV: begin
                w_res = '1;
                w_hi  = a;
            end
            default: ;
        endcase
    end

    // One shift-add step and one restoring-division step per cycle.
    assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};
    assign w_div_t    = {r_rem, r_q[WIDTH-1]};
    assign w_div_ge   = (w_div_t >= {1'b0, r_dvs});
    assign w_div_diff = w_div_t[WIDTH-1:0] - r_dvs;
    assign w_rem_next = w_div_ge ? w_div_diff : w_div_t[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_div_ge};

    // Control FSM, iteration registers and all architectural outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_fw      <= '0;
            r_p       <= '0;
            r_mcand   <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_dvs     <= '0;
            result    <= '0;
            result_hi <= '0;
            nzcv      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_fw <= flag_w;
                        if (alu_control == OP_MUL) begin
                            r_state <= MUL_RUN;
                            r_cnt   <= '0;
                            r_p     <= {{WIDTH{1'b0}}, b};
                            r_mcand <= a;
                            busy    <= 1'b1;
                        end else if (alu_control == OP_UDIV && b != '0) begin
                            r_state <= DIV_RUN;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_q     <= a;
                            r_dvs   <= b;
                            busy    <= 1'b1;
                        end else begin
                            result    <= w_res;
                            result_hi <= w_hi;
                            nzcv      <= f_nzcv(nzcv, flag_w, w_res, w_c, w_v);
                            done      <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    r_p   <= w_mul_next;
                    r_cnt <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        result    <= w_mul_next[WIDTH-1:0];
                        result_hi <= w_mul_next[2*WIDTH-1:WIDTH];
                        nzcv      <= f_nzcv(nzcv, r_fw, w_mul_next[WIDTH-1:0], 1'b0, 1'b0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        result    <= w_q_next;
                        result_hi <= w_rem_next;
                        nzcv      <= f_nzcv(nzcv, r_fw, w_q_next, 1'b0, 1'b0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_control = 4'd0;
    logic [1:0]  flag_w = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic [3:0]  nzcv;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .flag_w(flag_w), .a(a), .b(b), .result(result), .result_hi(result_hi),
        .nzcv(nzcv), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] r,
                                   output logic [31:0] h, output logic c, output logic v);
        logic [63:0]        p;
        longint             sx, sy, sr;
        logic signed [31:0] rs;
        int                 s;
        r = 32'd0; h = 32'd0; c = 1'b0; v = 1'b0;
        s  = int'(y[4:0]);
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            4'd0: begin
                p = {32'd0, x} + {32'd0, y}; r = p[31:0]; c = p[32];
                sr = sx + sy; rs = r; v = (sr != longint'(rs));
            end
            4'd1: begin
                r = x - y; c = (x >= y);
                sr = sx - sy; rs = r; v = (sr != longint'(rs));
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: begin r = x << s; if (s != 0) c = x[32 - s]; end
            4'd6: begin r = x >> s; if (s != 0) c = x[s - 1]; end
            4'd7: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; h = p[63:32]; end
            4'd8: begin
                if (y == 32'd0) begin r = 32'hFFFF_FFFF; h = x; end
                else begin r = x / y; h = x % y; end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] apply_flags(input logic [3:0] old, input logic [1:0] fw,
                                               input logic [31:0] r, input logic c,
                                               input logic v);
        logic [3:0] f;
        f = old;
        if (fw[1]) begin f[3] = r[31]; f[2] = (r == 32'd0); end
        if (fw[0]) begin f[1] = c; f[0] = v; end
        return f;
    endfunction

    // Model state: what the outputs must be after each edge.
    logic [31:0] m_result = '0, m_hi = '0;
    logic [3:0]  m_nzcv = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] p_res, p_hi;
    logic        p_c, p_v;
    logic [1:0]  p_fw;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_result = '0; m_hi = '0; m_nzcv = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_done = 1'b1;
                        m_result = p_res; m_hi = p_hi;
                        m_nzcv = apply_flags(m_nzcv, p_fw, p_res, p_c, p_v);
                    end
                end else if (start) begin
                    ref_op(alu_control, a, b, p_res, p_hi, p_c, p_v);
                    p_fw = flag_w;
                    if (alu_control == 4'd7 || (alu_control == 4'd8 && b != 32'd0)) begin
                        m_busy = 1'b1; m_left = 32;
                    end else begin
                        m_done = 1'b1;
                        m_result = p_res; m_hi = p_hi;
                        m_nzcv = apply_flags(m_nzcv, p_fw, p_res, p_c, p_v);
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("result", result, m_result);
            chk("result_hi", result_hi, m_hi);
            chk("nzcv", 32'(nzcv), 32'(m_nzcv));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
        end
    end

    task automatic go(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [1:0] fw);
        start = 1'b1; alu_control = op; a = aa; b = bb; flag_w = fw;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_result", result, 32'd0);
        chk("rst_nzcv", 32'(nzcv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        go(4'd0, 32'h7FFF_FFFF, 32'h1, 2'b11);
        chk("add_res", result, 32'h8000_0000);
        chk("add_nzcv", 32'(nzcv), 32'b1001);
        chk("add_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("add_done_pulse", 32'(done), 32'd0);

        go(4'd1, 32'd5, 32'd5, 2'b11);
        chk("sub_res", result, 32'd0);
        chk("sub_nzcv", 32'(nzcv), 32'b0110);
        go(4'd2, 32'hF0, 32'h0F, 2'b00);
        chk("and_res", result, 32'd0);
        chk("and_nzcv", 32'(nzcv), 32'b0110);
        chk("and_done", 32'(done), 32'd1);

        go(4'd7, 32'h0001_0000, 32'h0001_0000, 2'b10);
        chk("mul_busy", 32'(busy), 32'd1);
        go(4'd0, 32'd1, 32'd1, 2'b11);
        wait_done(lat);
        chk("mul_latency", 32'(lat + 1), 32'd32);
        chk("mul_res", result, 32'd0);
        chk("mul_hi", result_hi, 32'd1);
        chk("mul_nzcv", 32'(nzcv), 32'b0110);

        go(4'd8, 32'd100, 32'd7, 2'b10);
        wait_done(lat);
        chk("div_latency", 32'(lat), 32'd32);
        chk("div_res", result, 32'd14);
        chk("div_hi", result_hi, 32'd2);
        chk("div_nzcv", 32'(nzcv), 32'b0010);
        go(4'd8, 32'd9, 32'd0, 2'b11);
        chk("div0_done", 32'(done), 32'd1);
        chk("div0_res", result, 32'hFFFF_FFFF);
        chk("div0_hi", result_hi, 32'd9);
        chk("div0_nzcv", 32'(nzcv), 32'b1000);

        go(4'd6, 32'h3, 32'h1, 2'b01);
        chk("lsr_res", result, 32'h1);
        chk("lsr_nzcv", 32'(nzcv), 32'b1010);

        go(4'd7, 32'd3, 32'd5, 2'b11);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", result, 32'd0);
        chk("abort_nzcv", 32'(nzcv), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        go(4'd0, 32'd2, 32'd3, 2'b11);
        chk("post_rst_add", result, 32'd5);

        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ((op == 4'd7 || op == 4'd8) && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 6));
            start       = ($urandom_range(0, 3) != 0);
            alu_control = op;
            a           = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            flag_w      = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(lat);
        @(posedge clk); #1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
